sram_port_arbiter: RTL
======================

# sram_port_arbiter

Shares one single-port synchronous SRAM between the instruction-fetch port and the MEM-stage data port of the 5-stage pipeline. It grants one requester per cycle, with data priority and a bounded anti-starvation override for fetch. It routes the SRAM's one-cycle-latency read data back to the requester that issued the read. It also performs data address translation and byte-lane alignment of store data.

## Interface
- `STARVE_MAX`, default 4: maximum consecutive data grants while fetch is waiting; the legal range is 1..15.
- `clk` in 1: the single clock; all state updates on the rising edge.
- `resetn` in 1: synchronous reset, active low.
- `inst_req` in 1: fetch read request, held until granted.
- `inst_addr` in 32: fetch byte address, word-aligned.
- `inst_gnt` out 1: fetch request accepted this cycle (combinational).
- `inst_rvalid` out 1: fetch read data is valid this cycle.
- `inst_rdata` out 32: fetch read data.
- `data_req` in 1: data request, held until granted.
- `data_wen` in 4: byte write enables; 0 means read.
- `data_addr` in 32: data byte address.
- `data_wdata` in 32: store data, right-justified.
- `data_gnt` out 1: data request accepted this cycle (combinational).
- `data_rvalid` out 1: data read data is valid this cycle.
- `data_rdata` out 32: data read data.
- `sram_en` out 1: SRAM enable.
- `sram_wen` out 4: SRAM byte write enables.
- `sram_addr` out 32: SRAM address.
- `sram_wdata` out 32: SRAM write data.
- `sram_rdata` in 32: SRAM read data, valid one cycle after an enabled read.

## Operation
Arbitration (combinational, per cycle, only when `resetn`=1):
- Only one requester active: that requester is granted.
- Both active and `starve_cnt` < `STARVE_MAX`: data is granted.
- Both active and `starve_cnt` == `STARVE_MAX`: fetch is granted.
- At most one grant per cycle. No request: `sram_en`=0.

`starve_cnt` (4-bit register):
- Increments on a data grant while `inst_req`=1.
- Clears to 0 on a fetch grant, or in any cycle with `inst_req`=0.
- Saturates at `STARVE_MAX`; it is never compared beyond that value.

SRAM drive:
- Fetch grant: `sram_en`=1, `sram_wen`=0, `sram_addr`=translated `inst_addr`.
- Data grant: `sram_en`=1, `sram_wen`=`data_wen`, `sram_addr`=translated `data_addr`.
- Data grant, write data: `sram_wdata`=`data_wdata` shifted left by 8×`data_addr[1:0]`, zero-filled. Offset 1 gives `{wdata[23:0],8'h0}`, offset 2 gives `{wdata[15:0],16'h0}`, offset 3 gives `{wdata[7:0],24'h0}`.
- `sram_wdata` is 0 when no data grant.

Response tracking:
- `rd_owner` register holds one of NONE, INST, DATA. It is updated every cycle.
- Set to INST on a fetch grant, DATA on a data read grant (`data_wen`=0), and NONE otherwise.
- Data writes produce no rvalid.

Response outputs:
- `inst_rvalid` = (`rd_owner`==INST); `data_rvalid` = (`rd_owner`==DATA).
- Each port's rdata equals `sram_rdata` while that port's rvalid is 1.
- Otherwise each port's rdata equals its hold register, which captures `sram_rdata` on that port's rvalid cycle.

## Timing
- Grant and SRAM command are in the same cycle T, with no added latency.
- Read data and rvalid appear in cycle T+1 and last exactly one cycle.
- Back-to-back grants are allowed every cycle. Responses of consecutive reads pipeline, one per cycle, in grant order.
- A grant in T+1 does not disturb the response of T.
- Reset (`resetn`=0 at an edge) sets `starve_cnt`=0, `rd_owner`=NONE, and both hold registers to 0.
- While `resetn`=0, `inst_gnt`, `data_gnt`, `sram_en` and `sram_wen` are forced to 0.
- A read granted in the cycle before reset produces no rvalid, because `rd_owner` is cleared.
- Requests asserted during reset are granted in the first cycle with `resetn`=1.
- Both requesters withdrawing is not legal before grant; the behaviour in that case is unspecified.

## Configuration
- `SRAM_ARB_KSEG_MAP_EN` defined: if an address has `[31:28]` equal to 4'hA or 4'hB, `sram_addr` = address − 32'hA0000000. This applies to both ports. All other addresses pass through unchanged.
- `SRAM_ARB_KSEG_MAP_EN` undefined: `sram_addr` equals the granted address unchanged.
- Byte-lane alignment uses `data_addr[1:0]` and is unaffected by the macro.

## Test plan
- Single fetch read: `inst_req`=1, `inst_addr`=32'hBFC00000, macro defined → `inst_gnt`=1 and `sram_addr`=32'h1FC00000 in T. In T+1, `inst_rvalid`=1 and `inst_rdata`=`sram_rdata` (e.g. 32'h3C1D0001). Afterwards `inst_rdata` holds that value.
- Byte store alignment: `data_req`=1, `data_wen`=4'b0100, `data_addr`=32'h00000102, `data_wdata`=32'h000000AB → `sram_wdata`=32'h00AB0000 and `sram_wen`=4'b0100. No `data_rvalid` in T+1.
- Starvation: both requests held continuously with `STARVE_MAX`=4 → data granted in cycles 0–3 and fetch in cycle 4. `starve_cnt` then restarts and data is granted again in cycles 5–8.
- Interleaved responses: data read at T, fetch read at T+1 → `data_rvalid` at T+1 and `inst_rvalid` at T+2. Each port receives the `sram_rdata` of its own cycle, with no cross-talk.
- Reset mid-read: fetch granted at T, `resetn`=0 at the T+1 edge → `inst_rvalid` stays 0, `inst_rdata`=0, and all grants are 0 while `resetn` is low.
- Macro undefined: a data read at 32'hA0001000 → `sram_addr`=32'hA0001000.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one single-port synchronous SRAM between instruction fetch and MEM data.
// Define SRAM_ARB_KSEG_MAP_EN to fold 0xA/0xB segment addresses down by 32'hA0000000.
module sram_port_arbiter #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_gnt,
    output logic        inst_rvalid,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic [3:0]  data_wen,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_gnt,
    output logic        data_rvalid,
    output logic [31:0] data_rdata,
    output logic        sram_en,
    output logic [3:0]  sram_wen,
    output logic [31:0] sram_addr,
    output logic [31:0] sram_wdata,
    input  logic [31:0] sram_rdata
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_INST = 2'd1,
        OWN_DATA = 2'd2
    } owner_e;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [3:0]  starve_cnt_q, starve_cnt_d;
    owner_e      rd_owner_q, rd_owner_d;
    logic [31:0] inst_hold_q, inst_hold_d;
    logic [31:0] data_hold_q, data_hold_d;

    function automatic logic [31:0] xlate_addr(input logic [31:0] addr);
        logic [31:0] result;
        result = addr;
`ifdef SRAM_ARB_KSEG_MAP_EN
        if (addr[31:28] == 4'hA || addr[31:28] == 4'hB) begin
            result = addr - 32'hA000_0000;
        end
`endif
        return result;
    endfunction

    // Data wins by default; fetch wins once data has been granted STARVE_MAX times in a row.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        inst_gnt = 1'b0;
        data_gnt = 1'b0;
        if (resetn) begin
            if (inst_req && data_req) begin
                if (starve_cnt_q < STARVE_LIM) begin
                    data_gnt = 1'b1;
                end else begin
                    inst_gnt = 1'b1;
                end
            end else begin
                inst_gnt = inst_req;
                data_gnt = data_req;
            end
        end
    end

    always_comb begin
        sram_en    = inst_gnt | data_gnt;
        sram_wen   = 4'b0000;
        sram_addr  = 32'h0000_0000;
        sram_wdata = 32'h0000_0000;
        if (inst_gnt) begin
            sram_addr = xlate_addr(inst_addr);
        end else if (data_gnt) begin
            sram_wen   = data_wen;
            sram_addr  = xlate_addr(data_addr);
            sram_wdata = data_wdata << {data_addr[1:0], 3'b000};
        end
    end

    assign inst_rvalid = (rd_owner_q == OWN_INST);
    assign data_rvalid = (rd_owner_q == OWN_DATA);
    assign inst_rdata  = inst_rvalid ? sram_rdata : inst_hold_q;
    assign data_rdata  = data_rvalid ? sram_rdata : data_hold_q;

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!inst_req || inst_gnt) begin
            starve_cnt_d = 4'd0;
        end else if (data_gnt) begin
            starve_cnt_d = (starve_cnt_q >= STARVE_LIM) ? STARVE_LIM : starve_cnt_q + 4'd1;
        end

        if (inst_gnt) begin
            rd_owner_d = OWN_INST;
        end else if (data_gnt && data_wen == 4'b0000) begin
            rd_owner_d = OWN_DATA;
        end else begin
            rd_owner_d = OWN_NONE;
        end

        inst_hold_d = inst_rvalid ? sram_rdata : inst_hold_q;
        data_hold_d = data_rvalid ? sram_rdata : data_hold_q;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!resetn) begin
            // NOTE: the read-data hold registers are reset too, so a port reads 0 until its first response.
            starve_cnt_q <= 4'd0;
            rd_owner_q   <= OWN_NONE;
            inst_hold_q  <= 32'h0000_0000;
            data_hold_q  <= 32'h0000_0000;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            rd_owner_q   <= rd_owner_d;
            inst_hold_q  <= inst_hold_d;
            data_hold_q  <= data_hold_d;
        end
    end

endmodule
